// File: rtl/rx_packet_buffer.sv
// Receive-side byte buffer: PID capture, two-byte CRC holdoff pipeline and a
// 64-entry first-word-fall-through FIFO feeding the host-side reader.
module rx_packet_buffer #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] p_out,
    input  logic       load_buf,
    input  logic       w_enable,
    input  logic       store_pid,
    input  logic       flush,
    input  logic       r_error,
    input  logic       get_rx_data,
    output logic [7:0] old_2_byte,
    output logic [7:0] new_2_byte,
    output logic       done_2,
    output logic       done_64,
    output logic [3:0] rx_pid,
    output logic [7:0] rx_data,
    output logic [6:0] buffer_occupancy,
    output logic       rx_empty,
    output logic       rx_error
);

    localparam logic [6:0] FULL_LEVEL = 7'(DEPTH);

    logic [7:0] mem_r [0:63];
    logic [5:0] wptr_r;
    logic [5:0] rptr_r;
    logic [6:0] occ_r;
    logic [1:0] hold_cnt_r;
    logic [7:0] old_byte_r;
    logic [7:0] new_byte_r;
    logic       done_2_r;
    logic       done_64_r;
    logic [3:0] pid_r;
    logic       empty_r;
    logic       error_r;

    logic       wr_en_s;
    logic       rd_en_s;
    logic [6:0] occ_next_s;

    // Accept/drop decisions use the occupancy held before this edge; flush masks both.
    always_comb begin
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        occ_next_s = occ_r;
        if (flush) begin
            occ_next_s = 7'd0;
        end else begin
            wr_en_s = w_enable && (occ_r != FULL_LEVEL);
            rd_en_s = get_rx_data && (occ_r != 7'd0);
            if (wr_en_s && !rd_en_s) begin
                occ_next_s = occ_r + 7'd1;
            end else if (!wr_en_s && rd_en_s) begin
                occ_next_s = occ_r - 7'd1;
            end else begin
                occ_next_s = occ_r;
            end
        end
    end

    // Storage array; intentionally not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (n_rst && wr_en_s) begin
            mem_r[wptr_r] <= old_byte_r;
        end
    end

    // Control state: pointers, occupancy flags, holdoff pipeline, PID and sticky error.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_r     <= 6'd0;
            rptr_r     <= 6'd0;
            occ_r      <= 7'd0;
            hold_cnt_r <= 2'd0;
            old_byte_r <= 8'h00;
            new_byte_r <= 8'h00;
            done_2_r   <= 1'b0;
            done_64_r  <= 1'b0;
            pid_r      <= 4'h0;
            empty_r    <= 1'b1;
            error_r    <= 1'b0;
        end else if (flush) begin
            wptr_r     <= 6'd0;
            rptr_r     <= 6'd0;
            occ_r      <= 7'd0;
            hold_cnt_r <= 2'd0;
            old_byte_r <= 8'h00;
            new_byte_r <= 8'h00;
            done_2_r   <= 1'b0;
            done_64_r  <= 1'b0;
            pid_r      <= 4'h0;
            empty_r    <= 1'b1;
            error_r    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wptr_r <= wptr_r + 6'd1;
            end
            if (rd_en_s) begin
                rptr_r <= rptr_r + 6'd1;
            end
            occ_r     <= occ_next_s;
            done_64_r <= (occ_next_s == FULL_LEVEL);
            empty_r   <= (occ_next_s == 7'd0);

            // done_2 follows the saturating count: two loads fill the pipeline.
            if (load_buf) begin
                old_byte_r <= new_byte_r;
                new_byte_r <= p_out;
                done_2_r   <= (hold_cnt_r != 2'd0);
                if (hold_cnt_r != 2'd2) begin
                    hold_cnt_r <= hold_cnt_r + 2'd1;
                end
            end
            if (store_pid) begin
                pid_r <= p_out[3:0];
            end
            if (r_error) begin
                error_r <= 1'b1;
            end
        end
    end

    assign old_2_byte       = old_byte_r;
    assign new_2_byte       = new_byte_r;
    assign done_2           = done_2_r;
    assign done_64          = done_64_r;
    assign rx_pid           = pid_r;
    assign buffer_occupancy = occ_r;
    assign rx_empty         = empty_r;
    assign rx_error         = error_r;
    assign rx_data          = empty_r ? 8'h00 : mem_r[rptr_r];

endmodule

// File: tb/tb_rx_packet_buffer.sv
// Bench for rx_packet_buffer: explicit vector table for the PID/holdoff/packet
// flow plus a queue scoreboard model checked on every cycle.
module tb_rx_packet_buffer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] p_out;
    logic       load_buf, w_enable, store_pid, flush, r_error, get_rx_data;
    logic [7:0] old_2_byte, new_2_byte, rx_data;
    logic       done_2, done_64, rx_empty, rx_error;
    logic [3:0] rx_pid;
    logic [6:0] buffer_occupancy;

    int checks = 0;
    int errors = 0;

    // Bench model state
    logic [7:0] sb_q [$];
    logic [7:0] m_old, m_new;
    int         m_cnt;
    logic [3:0] m_pid;
    logic       m_err;

    typedef struct {
        logic [7:0] p;
        logic       ld, we, sp, fl, gt;
        logic [7:0] e_old, e_new;
        logic       e_d2;
        logic [6:0] e_occ;
        logic [7:0] e_data;
        logic [3:0] e_pid;
    } vec_t;

    vec_t vecs [15];

    rx_packet_buffer dut (
        .clk(clk), .n_rst(n_rst), .p_out(p_out), .load_buf(load_buf),
        .w_enable(w_enable), .store_pid(store_pid), .flush(flush),
        .r_error(r_error), .get_rx_data(get_rx_data),
        .old_2_byte(old_2_byte), .new_2_byte(new_2_byte), .done_2(done_2),
        .done_64(done_64), .rx_pid(rx_pid), .rx_data(rx_data),
        .buffer_occupancy(buffer_occupancy), .rx_empty(rx_empty), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_old = 8'h00; m_new = 8'h00; m_cnt = 0; m_pid = 4'h0; m_err = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":occ"}, {25'd0, buffer_occupancy}, sb_q.size());
        chk({tag, ":empty"}, {31'd0, rx_empty}, (sb_q.size() == 0) ? 32'd1 : 32'd0);
        chk({tag, ":done_64"}, {31'd0, done_64}, (sb_q.size() == 64) ? 32'd1 : 32'd0);
        chk({tag, ":rx_data"}, {24'd0, rx_data}, (sb_q.size() == 0) ? 32'd0 : {24'd0, sb_q[0]});
        chk({tag, ":done_2"}, {31'd0, done_2}, (m_cnt == 2) ? 32'd1 : 32'd0);
        chk({tag, ":old"}, {24'd0, old_2_byte}, {24'd0, m_old});
        chk({tag, ":new"}, {24'd0, new_2_byte}, {24'd0, m_new});
        chk({tag, ":pid"}, {28'd0, rx_pid}, {28'd0, m_pid});
        chk({tag, ":err"}, {31'd0, rx_error}, {31'd0, m_err});
    endtask

    // One clock: drive at negedge, advance the model, check 1ns after the edge.
    task automatic step(input string tag, input logic [7:0] p, input logic ld, input logic we,
                        input logic sp, input logic fl, input logic re, input logic gt);
        logic wr, rd;
        @(negedge clk);
        p_out = p; load_buf = ld; w_enable = we; store_pid = sp;
        flush = fl; r_error = re; get_rx_data = gt;
        if (fl) begin
            model_reset();
        end else begin
            wr = we && (sb_q.size() < 64);
            rd = gt && (sb_q.size() > 0);
            if (rd) void'(sb_q.pop_front());
            if (wr) sb_q.push_back(m_old);
            if (sp) m_pid = p[3:0];
            if (re) m_err = 1'b1;
            if (ld) begin
                m_old = m_new; m_new = p;
                if (m_cnt < 2) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check_model(tag);
        p_out = 8'h00; load_buf = 1'b0; w_enable = 1'b0; store_pid = 1'b0;
        flush = 1'b0; r_error = 1'b0; get_rx_data = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ":old"}, {24'd0, old_2_byte}, 32'h00);
        chk({tag, ":new"}, {24'd0, new_2_byte}, 32'h00);
        chk({tag, ":done_2"}, {31'd0, done_2}, 32'd0);
        chk({tag, ":done_64"}, {31'd0, done_64}, 32'd0);
        chk({tag, ":pid"}, {28'd0, rx_pid}, 32'h0);
        chk({tag, ":rx_data"}, {24'd0, rx_data}, 32'h00);
        chk({tag, ":occ"}, {25'd0, buffer_occupancy}, 32'd0);
        chk({tag, ":empty"}, {31'd0, rx_empty}, 32'd1);
        chk({tag, ":err"}, {31'd0, rx_error}, 32'd0);
    endtask

    initial begin
        //          p      ld    we    sp    fl    gt    old    new    d2    occ    data   pid
        vecs[0]  = '{8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 7'd0, 8'h00, 4'h3};
        vecs[1]  = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 7'd0, 8'h00, 4'h3};
        vecs[2]  = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 1'b1, 7'd0, 8'h00, 4'h3};
        vecs[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 7'd0, 8'h00, 4'h0};
        vecs[4]  = '{8'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA0, 1'b0, 7'd0, 8'h00, 4'h0};
        vecs[5]  = '{8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, 8'hA1, 1'b1, 7'd0, 8'h00, 4'h0};
        vecs[6]  = '{8'hA2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1, 8'hA2, 1'b1, 7'd1, 8'hA0, 4'h0};
        vecs[7]  = '{8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA2, 8'hA3, 1'b1, 7'd2, 8'hA0, 4'h0};
        vecs[8]  = '{8'hA4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA3, 8'hA4, 1'b1, 7'd3, 8'hA0, 4'h0};
        vecs[9]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA4, 8'hA5, 1'b1, 7'd4, 8'hA0, 4'h0};
        vecs[10] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA4, 8'hA5, 1'b1, 7'd3, 8'hA1, 4'h0};
        vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA4, 8'hA5, 1'b1, 7'd2, 8'hA2, 4'h0};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA4, 8'hA5, 1'b1, 7'd1, 8'hA3, 4'h0};
        vecs[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA4, 8'hA5, 1'b1, 7'd0, 8'h00, 4'h0};
        vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA4, 8'hA5, 1'b1, 7'd0, 8'h00, 4'h0};

        n_rst = 1'b0;
        p_out = 8'h00; load_buf = 1'b0; w_enable = 1'b0; store_pid = 1'b0;
        flush = 1'b0; r_error = 1'b0; get_rx_data = 1'b0;
        model_reset();
        #12;
        check_reset_values("por");
        @(negedge clk);
        n_rst = 1'b1;

        // Table: PID, holdoff, DATA packet with CRC holdoff, drain, empty read
        for (int i = 0; i < 15; i++) begin
            step($sformatf("vec%0d", i), vecs[i].p, vecs[i].ld, vecs[i].we,
                 vecs[i].sp, vecs[i].fl, 1'b0, vecs[i].gt);
            chk($sformatf("vec%0d:old", i), {24'd0, old_2_byte}, {24'd0, vecs[i].e_old});
            chk($sformatf("vec%0d:new", i), {24'd0, new_2_byte}, {24'd0, vecs[i].e_new});
            chk($sformatf("vec%0d:done_2", i), {31'd0, done_2}, {31'd0, vecs[i].e_d2});
            chk($sformatf("vec%0d:occ", i), {25'd0, buffer_occupancy}, {25'd0, vecs[i].e_occ});
            chk($sformatf("vec%0d:data", i), {24'd0, rx_data}, {24'd0, vecs[i].e_data});
            chk($sformatf("vec%0d:pid", i), {28'd0, rx_pid}, {28'd0, vecs[i].e_pid});
        end

        // Overflow: 64 writes fill, 65th dropped, read+write at full only reads
        step("ovf_flush", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++)
            step("ovf_fill", 8'(i + 8'h40), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_occ", {25'd0, buffer_occupancy}, 32'd64);
        chk("full_done_64", {31'd0, done_64}, 32'd1);
        step("ovf_65th", 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_occ", {25'd0, buffer_occupancy}, 32'd64);
        step("ovf_rw", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rw_full_occ", {25'd0, buffer_occupancy}, 32'd63);
        for (int i = 0; i < 63; i++)
            step("ovf_drain", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Pointer wrap: repeated 64-write/64-read bursts preserve order
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++)
                step("wrap_wr", 8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 64; i++)
                step("wrap_rd", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Random mix incl. simultaneous read/write at partial occupancy
        for (int i = 0; i < 300; i++)
            step("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'b0,
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));

        // Flush priority over write, read and error
        step("fp_flush", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("fp_pid", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            step("fp_fill", 8'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fp_pre_occ", {25'd0, buffer_occupancy}, 32'd10);
        chk("fp_pre_err", {31'd0, rx_error}, 32'd1);
        step("fp_all", 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("fp_occ", {25'd0, buffer_occupancy}, 32'd0);
        chk("fp_done_2", {31'd0, done_2}, 32'd0);
        chk("fp_err", {31'd0, rx_error}, 32'd0);
        chk("fp_pid", {28'd0, rx_pid}, 32'd0);
        step("empty_rd", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("empty_rd_occ", {25'd0, buffer_occupancy}, 32'd0);

        // Asynchronous reset mid-packet
        step("mr_pid", 8'hC9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step("mr_fill", 8'(8'h90 + i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        w_enable = 1'b1; load_buf = 1'b1;
        n_rst = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values("midrst_hold");
        w_enable = 1'b0; load_buf = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        step("post_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
